// File: rtl/ss_dst_fifo_pkg.sv
// Shared constants for the SS-DMA destination FIFO: bus widths and default geometry.
package ss_dst_fifo_pkg;
  localparam int unsigned SS_DATA_W     = 64;
  localparam int unsigned SS_WORD_W     = 32;
  localparam int unsigned SS_DEPTH_LOG2 = 4;
  localparam int unsigned SS_AFULL_LVL  = 2;
endpackage

// File: rtl/ss_fifo_ram.sv
// Register array for the destination FIFO: synchronous write, asynchronous read.
module ss_fifo_ram
  import ss_dst_fifo_pkg::*;
#(
  parameter int unsigned ADDR_W = SS_DEPTH_LOG2
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [SS_DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0]    raddr,
  output logic [SS_DATA_W-1:0] rdata
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [SS_DATA_W-1:0] mem [DEPTH];

  // Contents are intentionally not reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/ss_dst_fifo.sv
// 64-bit in / 32-bit show-ahead out destination FIFO, low word first.
// Define SS_DST_FIFO_LEVEL_EN to expose the d_level occupancy port.
module ss_dst_fifo
  import ss_dst_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = SS_DEPTH_LOG2,
  parameter int unsigned AFULL_LVL  = SS_AFULL_LVL
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 m_dst_putn,
  input  logic [SS_DATA_W-1:0] m_dst,
  output logic                 m_dst_full,
  output logic                 m_dst_afull,
  input  logic                 d_getn,
  output logic [SS_WORD_W-1:0] d_dat,
  output logic                 d_empty,
  input  logic                 d_clr,
`ifdef SS_DST_FIFO_LEVEL_EN
  output logic [DEPTH_LOG2:0]  d_level,
`endif
  output logic                 d_ovf
);
  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [PTR_W-1:0]     wp, rp, cnt, free;
  logic                 hs;
  logic                 put_ok, get_ok, put_rej;
  logic [SS_DATA_W-1:0] head;

  // Flags depend only on registered pointers, never on same-cycle strobes.
  assign cnt         = wp - rp;
  assign free        = PTR_W'(DEPTH) - cnt;
  assign m_dst_full  = (cnt == PTR_W'(DEPTH));
  assign d_empty     = (cnt == '0);
  assign m_dst_afull = (32'(free) <= 32'(AFULL_LVL));

  assign put_ok  = !m_dst_putn && !m_dst_full;
  assign put_rej = !m_dst_putn &&  m_dst_full;
  assign get_ok  = !d_getn && !d_empty;

  ss_fifo_ram #(.ADDR_W(DEPTH_LOG2)) u_ram (
    .clk   (wb_clk_i),
    .we    (put_ok && !d_clr),
    .waddr (wp[DEPTH_LOG2-1:0]),
    .wdata (m_dst),
    .raddr (rp[DEPTH_LOG2-1:0]),
    .rdata (head)
  );

  assign d_dat = hs ? head[SS_DATA_W-1:SS_WORD_W] : head[SS_WORD_W-1:0];

`ifdef SS_DST_FIFO_LEVEL_EN
  assign d_level = cnt;
`endif

  // Pointer, half-select and overflow state; flush wins over any strobe.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wp    <= '0;
      rp    <= '0;
      hs    <= 1'b0;
      d_ovf <= 1'b0;
    end else if (d_clr) begin
      wp    <= '0;
      rp    <= '0;
      hs    <= 1'b0;
      d_ovf <= 1'b0;
    end else begin
      if (put_ok)  wp    <= wp + PTR_W'(1);
      if (put_rej) d_ovf <= 1'b1;
      if (get_ok) begin
        hs <= ~hs;
        if (hs) rp <= rp + PTR_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_ss_dst_fifo.sv
// Self-checking bench for ss_dst_fifo: vector table, corner sequences, random vs. word-queue model.
module tb_ss_dst_fifo;
  localparam int DEPTH = 16;
  localparam int AFULL = 2;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        m_dst_putn;
  logic [63:0] m_dst;
  logic        m_dst_full;
  logic        m_dst_afull;
  logic        d_getn;
  logic [31:0] d_dat;
  logic        d_empty;
  logic        d_clr;
  logic        d_ovf;
`ifdef SS_DST_FIFO_LEVEL_EN
  logic [4:0]  d_level;
`endif

  ss_dst_fifo #(.DEPTH_LOG2(4), .AFULL_LVL(AFULL)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .m_dst_putn  (m_dst_putn),
    .m_dst       (m_dst),
    .m_dst_full  (m_dst_full),
    .m_dst_afull (m_dst_afull),
    .d_getn      (d_getn),
    .d_dat       (d_dat),
    .d_empty     (d_empty),
    .d_clr       (d_clr),
`ifdef SS_DST_FIFO_LEVEL_EN
    .d_level     (d_level),
`endif
    .d_ovf       (d_ovf)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model: the stream of 32-bit words still to be read, plus sticky overflow.
  logic [31:0] q[$];
  bit          m_ovf;

  function automatic int ents();
    return (q.size() + 1) / 2;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("empty", 64'(d_empty), 64'(q.size() == 0));
    chk("full",  64'(m_dst_full), 64'(ents() == DEPTH));
    chk("afull", 64'(m_dst_afull), 64'((DEPTH - ents()) <= AFULL));
    chk("ovf",   64'(d_ovf), 64'(m_ovf));
    if (q.size() != 0) chk("dat", 64'(d_dat), 64'(q[0]));
`ifdef SS_DST_FIFO_LEVEL_EN
    chk("level", 64'(d_level), 64'(ents()));
`endif
  endtask

  task automatic step(input logic putn, input logic [63:0] data, input logic getn, input logic clr);
    bit pre_full, pre_empty;
    m_dst_putn = putn;
    m_dst      = data;
    d_getn     = getn;
    d_clr      = clr;
    pre_full   = (ents() == DEPTH);
    pre_empty  = (q.size() == 0);
    @(posedge wb_clk_i);
    #1;
    if (clr) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      if (!getn && !pre_empty) void'(q.pop_front());
      if (!putn) begin
        if (pre_full) m_ovf = 1'b1;
        else begin
          q.push_back(data[31:0]);
          q.push_back(data[63:32]);
        end
      end
    end
    m_dst_putn = 1'b1;
    d_getn     = 1'b1;
    d_clr      = 1'b0;
    check_model();
  endtask

  typedef struct {
    logic        putn;
    logic [63:0] data;
    logic        getn;
    logic        clr;
    logic        e_empty;
    logic [31:0] e_dat;
    logic        e_ovf;
  } vec_t;

  vec_t vt[8];

  function automatic logic [63:0] ent_val(input int i);
    return {32'hA000_0000 | 32'(i), 32'h5000_0000 | 32'(i)};
  endfunction

  initial begin
    int words;
    logic [31:0] exp_w;

    vt[0] = '{1'b0, 64'h11112222_33334444, 1'b1, 1'b0, 1'b0, 32'h33334444, 1'b0};
    vt[1] = '{1'b1, 64'h0,                 1'b0, 1'b0, 1'b0, 32'h11112222, 1'b0};
    vt[2] = '{1'b1, 64'h0,                 1'b0, 1'b0, 1'b1, 32'h0,        1'b0};
    vt[3] = '{1'b1, 64'h0,                 1'b0, 1'b0, 1'b1, 32'h0,        1'b0};
    vt[4] = '{1'b0, 64'hDEADBEEF_CAFEF00D, 1'b1, 1'b0, 1'b0, 32'hCAFEF00D, 1'b0};
    vt[5] = '{1'b0, 64'h01234567_89ABCDEF, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0};
    vt[6] = '{1'b0, 64'hFFFF0000_FFFF0000, 1'b0, 1'b1, 1'b1, 32'h0,        1'b0};
    vt[7] = '{1'b0, 64'h55556666_77778888, 1'b1, 1'b0, 1'b0, 32'h77778888, 1'b0};

    wb_rst_i   = 1'b0;
    m_dst_putn = 1'b1;
    m_dst      = '0;
    d_getn     = 1'b1;
    d_clr      = 1'b0;
    m_ovf      = 1'b0;
    repeat (2) @(posedge wb_clk_i);
    #1;
    check_model();
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    #1;

    // Vector table: basic put/get ordering, empty read, flush with strobes.
    for (int i = 0; i < 8; i++) begin
      step(vt[i].putn, vt[i].data, vt[i].getn, vt[i].clr);
      chk("vec_empty", 64'(d_empty), 64'(vt[i].e_empty));
      if (!vt[i].e_empty) chk("vec_dat", 64'(d_dat), 64'(vt[i].e_dat));
      chk("vec_ovf", 64'(d_ovf), 64'(vt[i].e_ovf));
    end

    // Fill to full, overflow, then drain in order.
    step(1'b1, 64'h0, 1'b1, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, ent_val(i), 1'b1, 1'b0);
      chk("fill_afull", 64'(m_dst_afull), 64'(i >= 13));
      chk("fill_full",  64'(m_dst_full),  64'(i == 15));
    end
    step(1'b0, 64'hBAD0BAD0_BAD0BAD0, 1'b1, 1'b0);
    chk("ovf_17th", 64'(d_ovf), 64'h1);
    for (int k = 0; k < 2 * DEPTH; k++) begin
      exp_w = (k % 2 == 1) ? ent_val(k / 2)[63:32] : ent_val(k / 2)[31:0];
      chk("drain_dat", 64'(d_dat), 64'(exp_w));
      step(1'b1, 64'h0, 1'b0, 1'b0);
    end
    chk("drain_empty", 64'(d_empty), 64'h1);
    chk("drain_ovf_sticky", 64'(d_ovf), 64'h1);

    // Full FIFO: put in the same cycle as the last-half get is rejected.
    step(1'b1, 64'h0, 1'b1, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, ent_val(i + 32), 1'b1, 1'b0);
    step(1'b1, 64'h0, 1'b0, 1'b0);
    chk("half_still_full", 64'(m_dst_full), 64'h1);
    step(1'b0, 64'h77777777_77777777, 1'b0, 1'b0);
    chk("edge_ovf",   64'(d_ovf), 64'h1);
    chk("edge_full",  64'(m_dst_full), 64'h0);
    chk("edge_afull", 64'(m_dst_afull), 64'h1);
`ifdef SS_DST_FIFO_LEVEL_EN
    chk("edge_level", 64'(d_level), 64'd15);
`endif
    words = 0;
    for (int n = 0; n < 40 && !d_empty; n++) begin
      words++;
      step(1'b1, 64'h0, 1'b0, 1'b0);
    end
    chk("edge_remaining_words", 64'(words), 64'd30);

    // Balanced streaming across pointer wrap: one entry every other cycle, one word per cycle.
    step(1'b1, 64'h0, 1'b1, 1'b1);
    for (int c = 0; c < 100; c++)
      step(c % 2 == 1, {$urandom, $urandom}, 1'b0, 1'b0);

    // Asynchronous reset mid-transfer.
    for (int i = 0; i < 5; i++) step(1'b0, {$urandom, $urandom}, 1'b1, 1'b0);
    step(1'b0, {$urandom, $urandom}, 1'b0, 1'b0);
    #2 wb_rst_i = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    chk("arst_empty", 64'(d_empty), 64'h1);
    chk("arst_full",  64'(m_dst_full), 64'h0);
    chk("arst_afull", 64'(m_dst_afull), 64'h0);
    chk("arst_ovf",   64'(d_ovf), 64'h0);
`ifdef SS_DST_FIFO_LEVEL_EN
    chk("arst_level", 64'(d_level), 64'h0);
`endif
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    #1;

    // Random traffic with varying bias against the word-queue model.
    for (int c = 0; c < 600; c++) begin
      int pb;
      pb = (c / 100) % 3;
      step(($urandom_range(0, 3) < 32'(pb + 1)) ? 1'b0 : 1'b1,
           {$urandom, $urandom},
           ($urandom_range(0, 3) < 32'(3 - pb)) ? 1'b0 : 1'b1,
           ($urandom_range(0, 63) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
